alarm_controller: RTL

Sequencing controller for the alarm sound generator in the digital-clock design. Compares the running BCD time against the stored BCD alarm time, then schedules ringing, snooze and stop. Its RING output drives the sound generator's CE input directly. Snooze and stop are single-cycle button pulses from the debouncer.

---
 rtl/alarm_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alarm_controller.sv
// ---------------------------------------------------------------------------
// alarm_controller
//
// Sequences the alarm sound generator of the digital clock. It compares the
// running BCD time with the stored BCD alarm time, then schedules ringing,
// snoozing and stopping. RING drives the sound generator's CE input directly.
//
// Ports:
//   CP          system clock, all state changes on its rising edge
//   CR          asynchronous active-high reset
//   TICK_1HZ    one-CP-cycle pulse, once per second
//   ALARM_EN    alarm armed switch (level)
//   HOUR/MINUTE/SECOND   current time, BCD
//   AL_HOUR/AL_MINUTE    alarm time, BCD
//   SNOOZE, STOP         single-cycle debounced button pulses
//   RING        registered enable for the sound generator
//   SNOOZING    registered, high while snoozing
//   SNOOZE_CNT  snoozes used in the current alarm event
// ---------------------------------------------------------------------------
module alarm_controller #(
  parameter int RING_SECONDS   = 60,   // 1..511
  parameter int SNOOZE_SECONDS = 300,  // 1..511
  parameter int MAX_SNOOZE     = 3     // 0..3
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       TICK_1HZ,
  input  logic       ALARM_EN,
  input  logic [7:0] HOUR,
  input  logic [7:0] MINUTE,
  input  logic [7:0] SECOND,
  input  logic [7:0] AL_HOUR,
  input  logic [7:0] AL_MINUTE,
  input  logic       SNOOZE,
  input  logic       STOP,
  output logic       RING,
  output logic       SNOOZING,
  output logic [1:0] SNOOZE_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [8:0] RING_TC   = 9'(RING_SECONDS);
  localparam logic [8:0] SNOOZE_TC = 9'(SNOOZE_SECONDS);
  localparam logic [1:0] MAX_SN    = 2'(MAX_SNOOZE);

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [1:0] snooze_cnt_q, snooze_cnt_d;
  logic       ring_q, ring_d;
  logic       snoozing_q, snoozing_d;

  // Raw 8-bit equality; no BCD validation is done on either operand.
  logic time_at_alarm;
  logic match;
  assign time_at_alarm = (HOUR == AL_HOUR) && (MINUTE == AL_MINUTE) && (SECOND == 8'h00);
  assign match         = ALARM_EN && time_at_alarm;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    snooze_cnt_d = snooze_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (match) begin
          state_d      = ST_RINGING;
          cnt_d        = '0;
          snooze_cnt_d = '0;
        end
      end

      ST_RINGING: begin
        // Priority: disarm > stop > snooze > tick.
        if (!ALARM_EN) begin
          state_d = ST_IDLE;
        end else if (STOP) begin
          state_d = ST_HOLDOFF;
        end else if (SNOOZE && (snooze_cnt_q < MAX_SN)) begin
          state_d      = ST_SNOOZE;
          snooze_cnt_d = snooze_cnt_q + 2'd1;
          cnt_d        = '0;
        end else if (TICK_1HZ && (cnt_q < RING_TC)) begin
          // An exhausted snooze press falls through here, so a coincident
          // tick is still counted.
          cnt_d = cnt_q + 9'd1;
          if (cnt_d == RING_TC) begin
            state_d = ST_HOLDOFF;
          end
        end
      end

      ST_SNOOZE: begin
        // Further snooze presses are ignored while snoozing.
        if (!ALARM_EN) begin
          state_d = ST_IDLE;
        end else if (STOP) begin
          state_d = ST_HOLDOFF;
        end else if (TICK_1HZ && (cnt_q < SNOOZE_TC)) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_d == SNOOZE_TC) begin
            state_d = ST_RINGING;
            cnt_d   = '0;
          end
        end
      end

      ST_HOLDOFF: begin
        // Wait out the alarm second so IDLE cannot immediately retrigger.
        if (!time_at_alarm) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs decoded from the next state so they line up with the transition.
    ring_d     = (state_d == ST_RINGING);
    snoozing_d = (state_d == ST_SNOOZE);
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      snooze_cnt_q <= '0;
      ring_q       <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      ring_q       <= ring_d;
      snoozing_q   <= snoozing_d;
    end
  end

  assign RING       = ring_q;
  assign SNOOZING   = snoozing_q;
  assign SNOOZE_CNT = snooze_cnt_q;

endmodule
